ones_count_accumulator: RTL and testbench

ONES_COUNT_ACCUMULATOR -- requirements
Module: ones_count_accumulator

---
 rtl/ones_count_accumulator.sv | 103 ++++++++++
 tb/tb_ones_count_accumulator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_accumulator.sv
// Frame accumulator: sums CHUNKS two-bit partial one's-counts {y1,y0} per frame
// and publishes the total on count with a one-cycle done pulse.
module ones_count_accumulator #(
  parameter int CHUNKS = 8,
  parameter int OUT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             y1,
  input  logic             y0,
  output logic             in_ready,
  output logic [OUT_W-1:0] count,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

  if (CHUNKS < 2 || CHUNKS > 64) begin : g_bad_chunks
    $error("ones_count_accumulator: CHUNKS must be in 2..64");
  end
  if (OUT_W < $clog2(3 * CHUNKS + 1)) begin : g_bad_out_w
    $error("ones_count_accumulator: OUT_W too narrow for 3*CHUNKS");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               xfer;
  logic [OUT_W-1:0]   sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    xfer    = in_ready_q && in_valid;
    sum     = acc_q + OUT_W'({y1, y0});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          // The final slice is folded into count on the same edge that leaves ACC.
          if (cnt_q == LAST) begin
            state_d = DONE;
            count_d = sum;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    in_ready_d = (state_d == ACC);
    busy_d     = (state_d == ACC);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Randomized bench for ones_count_accumulator: the driver pushes each frame's
// expected sum and done cycle; a negedge monitor pops and checks on done.
module tb_ones_count_accumulator;

  localparam int CHUNKS = 8;
  localparam int OUT_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             y1;
  logic             y0;
  logic             in_ready;
  logic [OUT_W-1:0] count;
  logic             done;
  logic             busy;

  always #5 clk = ~clk;

  ones_count_accumulator #(.CHUNKS(CHUNKS), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .y1       (y1),
    .y0       (y0),
    .in_ready (in_ready),
    .count    (count),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    int sum;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   held   = 0;
  int   sl[CHUNKS];
  int   gp[CHUNKS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs only move on posedge, so negedge sampling is race-free.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 0;
      chk("reset_count", 32'(count), 0);
    end else if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending frame (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("done_count", 32'(count), e.sum);
        chk("done_cycle", cyc, e.cyc);
        chk("done_busy", 32'(busy), 0);
        chk("done_in_ready", 32'(in_ready), 0);
        held = e.sum;
      end
    end else begin
      chk("count_held", 32'(count), held);
    end
  end

  task automatic garbage_y();
    y1 = 1'($urandom);
    y0 = 1'($urandom);
  endtask

  // Entered just after a negedge with the DUT idle; returns at the IDLE negedge after DONE.
  task automatic run_frame(input bit hold_start);
    int s = 0;
    start    = 1'b1;
    in_valid = 1'b0;
    garbage_y();
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("acc_in_ready", 32'(in_ready), 1);
    chk("acc_busy", 32'(busy), 1);
    for (int i = 0; i < CHUNKS; i++) begin
      for (int g = 0; g < gp[i]; g++) begin
        in_valid = 1'b0;
        garbage_y();
        @(negedge clk);
      end
      in_valid = 1'b1;
      y1 = sl[i][1];
      y0 = sl[i][0];
      s += sl[i];
      if (i == CHUNKS - 1) q.push_back('{s, cyc + 1});
      @(negedge clk);
    end
    in_valid = 1'b0;
    garbage_y();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_junk(input int n);
    for (int k = 0; k < n; k++) begin
      start    = 1'b0;
      in_valid = 1'b1;
      y1       = 1'b1;
      y0       = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic fill(input int v, input int maxgap);
    for (int i = 0; i < CHUNKS; i++) begin
      sl[i] = (v < 0) ? int'($urandom_range(0, 3)) : v;
      gp[i] = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    y1       = 1'b0;
    y0       = 1'b0;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle_junk(2);

    // All-threes frame, no gaps: 24.
    fill(3, 0);
    run_frame(1'b0);
    // All-zero frame: 24 held until this done, then 0.
    fill(0, 0);
    run_frame(1'b0);
    // Fixed slices with random gaps: 10.
    sl = '{1, 0, 2, 3, 1, 1, 0, 2};
    for (int i = 0; i < CHUNKS; i++) gp[i] = int'($urandom_range(0, 3));
    run_frame(1'b0);
    // start held through ACC and DONE, then junk in IDLE.
    fill(-1, 2);
    run_frame(1'b1);
    idle_junk(3);
    // Back-to-back frames.
    fill(-1, 0);
    run_frame(1'b0);
    fill(-1, 1);
    run_frame(1'b0);
    // Random frames.
    for (int f = 0; f < 20; f++) begin
      fill(-1, 3);
      run_frame(1'b0);
      if ($urandom_range(0, 1) == 1) idle_junk(int'($urandom_range(1, 3)));
    end

    // Mid-frame asynchronous reset after three transfers.
    fill(3, 0);
    run_frame(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      y1 = 1'b1;
      y0 = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle_junk(3);
    fill(1, 0);
    run_frame(1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_done: got %0d frames without done expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
